// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// Shares the single RTC register-bus transaction engine among three requesters:
// init sequencer (0), time/alarm writer (1) and periodic time reader (2).
// Fixed priority 0 > 1 > 2. A requester that keeps requesting keeps the
// engine for up to BURST_MAX back-to-back grants. Only one transaction is in
// flight at a time. A watchdog aborts a transaction if the engine never
// answers.
module rtc_bus_arbiter #(
    parameter int               TO_W      = 12,
    parameter logic [TO_W-1:0]  TIMEOUT   = 12'd200,
    parameter logic [3:0]       BURST_MAX = 4'd13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  wr_en,
    input  logic [23:0] addr_in,
    input  logic [23:0] wdata_in,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic [2:0]  err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        bus_start,
    output logic        bus_wr,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t          state_r;
    logic [TO_W-1:0] watchdog_r;
    logic [3:0]      burst_cnt_r;
    logic [1:0]      last_r;

    logic [2:0]      last_hot_s;
    logic [2:0]      others_s;
    logic [1:0]      pick_s;
    logic [3:0]      burst_next_s;
    logic            sel_wr_s;
    logic [7:0]      sel_addr_s;
    logic [7:0]      sel_wdata_s;

    // Index (0..2) to one-hot requester mask.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] hot;
        case (idx)
            2'd0:    hot = 3'b001;
            2'd1:    hot = 3'b010;
            2'd2:    hot = 3'b100;
            default: hot = 3'b000;
        endcase
        return hot;
    endfunction

    // Owner choice for the next arbitration: the previous owner stays while it
    // still requests and has burst budget left; otherwise the lowest-index
    // requester other than the previous owner, falling back to the previous
    // owner (with a fresh burst count) when nobody else is waiting.
    always_comb begin
        last_hot_s = onehot3(last_r);
        others_s   = req & ~last_hot_s;
        if (((req & last_hot_s) != 3'b000) && (burst_cnt_r < BURST_MAX)) begin
            pick_s = last_r;
        end else if (others_s[0]) begin
            pick_s = 2'd0;
        end else if (others_s[1]) begin
            pick_s = 2'd1;
        end else if (others_s[2]) begin
            pick_s = 2'd2;
        end else begin
            pick_s = last_r;
        end
        if ((pick_s == last_r) && (burst_cnt_r < BURST_MAX)) begin
            burst_next_s = burst_cnt_r + 4'd1;
        end else begin
            burst_next_s = 4'd1;
        end
    end

    // Operand mux for the chosen requester's byte lanes.
    always_comb begin
        sel_wr_s    = wr_en[pick_s];
        sel_addr_s  = addr_in[{pick_s, 3'b000} +: 8];
        sel_wdata_s = wdata_in[{pick_s, 3'b000} +: 8];
    end

    // Transaction FSM; all outputs are registered and pulses last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            watchdog_r  <= '0;
            burst_cnt_r <= 4'd0;
            last_r      <= 2'd0;
            grant       <= 3'b000;
            done        <= 3'b000;
            err         <= 3'b000;
            rdata       <= 8'h00;
            busy        <= 1'b0;
            bus_start   <= 1'b0;
            bus_wr      <= 1'b0;
            bus_addr    <= 8'h00;
            bus_wdata   <= 8'h00;
        end else begin
            bus_start <= 1'b0;
            done      <= 3'b000;
            err       <= 3'b000;
            case (state_r)
                IDLE: begin
                    if (req != 3'b000) begin
                        grant       <= onehot3(pick_s);
                        last_r      <= pick_s;
                        burst_cnt_r <= burst_next_s;
                        bus_wr      <= sel_wr_s;
                        bus_addr    <= sel_addr_s;
                        bus_wdata   <= sel_wdata_s;
                        bus_start   <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        grant <= 3'b000;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    // bus_done in this cycle belongs to nothing we launched.
                    watchdog_r <= '0;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (bus_done) begin
                        // A completion beats a simultaneous timeout.
                        if (!bus_wr) begin
                            rdata <= bus_rdata;
                        end else begin
                            rdata <= rdata;
                        end
                        done    <= grant;
                        state_r <= COMPLETE;
                    end else if (watchdog_r == (TIMEOUT - {{(TO_W-1){1'b0}}, 1'b1})) begin
                        done    <= grant;
                        err     <= grant;
                        state_r <= COMPLETE;
                    end else begin
                        watchdog_r <= watchdog_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                COMPLETE: begin
                    grant   <= 3'b000;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    grant   <= 3'b000;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: a cycle-timeline model predicts the
// outputs every cycle, and directed scenarios pin latencies, grant order,
// burst limits, timeout and reset abort with hand-computed literals.
module tb_rtc_bus_arbiter;

    localparam int TIMEOUT   = 200;
    localparam int BURST_MAX = 13;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  wr_en = 3'b000;
    logic [23:0] addr_in = 24'h0;
    logic [23:0] wdata_in = 24'h0;
    logic [2:0]  grant, done, err;
    logic [7:0]  rdata;
    logic        busy, bus_start, bus_wr;
    logic [7:0]  bus_addr, bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_done = 1'b0;

    rtc_bus_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .wr_en(wr_en),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .grant(grant), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .bus_start(bus_start), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done)
    );

    always #5 clk = ~clk;

    // ---------------- cycle counter and reference model ----------------
    int cyc = 0;
    int cyc_next;
    assign cyc_next = cyc + 1;

    bit        m_valid = 1'b0;
    bit        m_active = 1'b0;
    int        m_a = 0;
    int        m_c = -1;
    int        m_owner = 0;
    bit        m_err = 1'b0;
    logic      m_wr = 1'b0;
    logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'h00;
    int        m_last = 0;
    int        m_cnt = 0;
    int        m_next_arb = 0;
    int        m_pick;

    function automatic int pick(input logic [2:0] r, input int last, input int cnt);
        if (r[last] && cnt < BURST_MAX) return last;
        for (int i = 0; i < 3; i++) if (r[i] && i != last) return i;
        return last;
    endfunction

    // Model's arbitration choice for the current request vector.
    always_comb m_pick = pick(req, m_last, m_cnt);

    // Model timeline: arbitration edge a -> start in cycle a, waiting from a+1,
    // completion cycle c decided by bus_done or the timeout, idle afterwards.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_valid <= 1'b1; m_active <= 1'b0; m_c <= -1; m_err <= 1'b0;
            m_wr <= 1'b0; m_addr <= 8'h00; m_wdata <= 8'h00; m_rdata <= 8'h00;
            m_last <= 0; m_cnt <= 0; m_next_arb <= cyc_next + 1;
        end else if (m_valid) begin
            if (!m_active) begin
                if (cyc_next >= m_next_arb && req != 3'b000) begin
                    m_active <= 1'b1; m_a <= cyc_next; m_c <= -1; m_err <= 1'b0;
                    m_owner <= m_pick; m_last <= m_pick;
                    m_cnt <= (m_pick == m_last && m_cnt < BURST_MAX) ? m_cnt + 1 : 1;
                    m_wr <= wr_en[m_pick];
                    m_addr <= addr_in[8*m_pick +: 8];
                    m_wdata <= wdata_in[8*m_pick +: 8];
                end
            end else if (m_c < 0) begin
                if (cyc_next >= m_a + 2) begin
                    if (bus_done) begin
                        m_c <= cyc_next;
                        if (!m_wr) m_rdata <= bus_rdata;
                    end else if (cyc_next == m_a + 1 + TIMEOUT) begin
                        m_c <= cyc_next;
                        m_err <= 1'b1;
                    end
                end
            end else if (cyc_next == m_c + 1) begin
                m_active <= 1'b0;
                m_next_arb <= cyc_next + 1;
            end
        end
    end

    // ---------------- bench state ----------------
    int checks = 0;
    int failures = 0;

    logic [16:0] q0[$], q1[$], q2[$];
    logic [7:0]  mem [256];
    int          eng_delay = 0;
    int          eng_cnt = 0;
    logic [7:0]  eng_addr = 8'h00;
    logic [16:0] eng_log[$];
    int          start_cyc[$];
    logic [2:0]  start_grant[$];
    int          done_cyc[$];
    logic [2:0]  done_val[$], done_err[$];
    logic [7:0]  done_rdata[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        req[0] = (q0.size() > 0);
        req[1] = (q1.size() > 0);
        req[2] = (q2.size() > 0);
        if (req[0]) {wr_en[0], addr_in[7:0],   wdata_in[7:0]}   = q0[0];
        if (req[1]) {wr_en[1], addr_in[15:8],  wdata_in[15:8]}  = q1[0];
        if (req[2]) {wr_en[2], addr_in[23:16], wdata_in[23:16]} = q2[0];
    endtask

    task automatic push(input int who, input logic wr, input logic [7:0] a, input logic [7:0] d);
        case (who)
            0:       q0.push_back({wr, a, d});
            1:       q1.push_back({wr, a, d});
            default: q2.push_back({wr, a, d});
        endcase
        refresh();
    endtask

    // One cycle: compare against the model, log events, run engine and requesters.
    task automatic tick();
        logic [2:0] eg;
        @(negedge clk);
        if (m_valid) begin
            eg = m_active ? 3'(1 << m_owner) : 3'b000;
            chk("grant", 32'(grant), 32'(eg));
            chk("busy", 32'(busy), 32'(m_active));
            chk("bus_start", 32'(bus_start), (m_active && cyc == m_a) ? 32'd1 : 32'd0);
            chk("done", 32'(done), (m_active && cyc == m_c) ? 32'(eg) : 32'd0);
            chk("err", 32'(err), (m_active && cyc == m_c && m_err) ? 32'(eg) : 32'd0);
            chk("rdata", 32'(rdata), 32'(m_rdata));
            chk("bus_wr", 32'(bus_wr), 32'(m_wr));
            chk("bus_addr", 32'(bus_addr), 32'(m_addr));
            chk("bus_wdata", 32'(bus_wdata), 32'(m_wdata));
        end
        if (bus_start) begin start_cyc.push_back(cyc); start_grant.push_back(grant); end
        if (done != 3'b000) begin
            done_cyc.push_back(cyc); done_val.push_back(done);
            done_err.push_back(err); done_rdata.push_back(rdata);
        end
        if (reset) begin
            eng_cnt = 0; bus_done = 1'b0;
        end else if (bus_start) begin
            eng_cnt = eng_delay; eng_addr = bus_addr; bus_done = 1'b0;
            if (bus_wr) mem[bus_addr] = bus_wdata;
            eng_log.push_back({bus_wr, bus_addr, bus_wdata});
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            bus_done = (eng_cnt == 0);
            bus_rdata = mem[eng_addr];
        end else begin
            bus_done = 1'b0;
        end
        if (done[0] && q0.size() > 0) void'(q0.pop_front());
        if (done[1] && q1.size() > 0) void'(q1.pop_front());
        if (done[2] && q2.size() > 0) void'(q2.pop_front());
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin tick(); n++; end
        chk(name, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        repeat (4) tick();
    endtask

    logic [7:0] init_addr [13] = '{8'h02, 8'h02, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                   8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
    logic [2:0] t2_order [3] = '{3'b001, 3'b010, 3'b100};

    initial begin
        int b, bd, eb, t0, n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h64;

        // 1: single read, latency and data
        do_reset(); eng_delay = 5;
        b = start_cyc.size(); bd = done_cyc.size();
        push(2, 1'b0, 8'h21, 8'h00); t0 = cyc;
        drain(100, "t1_drain");
        chk("t1_nstart", 32'(start_cyc.size() - b), 32'd1);
        chk("t1_ndone", 32'(done_cyc.size() - bd), 32'd1);
        if (start_cyc.size() > b && done_cyc.size() > bd) begin
            chk("t1_start_lat", 32'(start_cyc[b] - t0), 32'd1);
            chk("t1_owner", 32'(start_grant[b]), 32'h4);
            chk("t1_done_lat", 32'(done_cyc[bd] - start_cyc[b]), 32'd6);
            chk("t1_done", 32'(done_val[bd]), 32'h4);
            chk("t1_rdata", 32'(done_rdata[bd]), 32'h45);
        end

        // 2: all three at once, priority order and turnaround gap
        do_reset(); eng_delay = 2;
        b = start_cyc.size(); bd = done_cyc.size();
        push(0, 1'b0, 8'h10, 8'h00); push(1, 1'b0, 8'h11, 8'h00); push(2, 1'b0, 8'h12, 8'h00);
        drain(200, "t2_drain");
        chk("t2_nstart", 32'(start_cyc.size() - b), 32'd3);
        if (start_cyc.size() >= b + 3 && done_cyc.size() >= bd + 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t2_owner", 32'(start_grant[b+i]), 32'(t2_order[i]));
                chk("t2_done", 32'(done_val[bd+i]), 32'(t2_order[i]));
            end
            chk("t2_gap1", 32'(start_cyc[b+1] - done_cyc[bd]), 32'd2);
            chk("t2_gap2", 32'(start_cyc[b+2] - done_cyc[bd+1]), 32'd2);
            chk("t2_rdata0", 32'(done_rdata[bd]), 32'h74);
            chk("t2_rdata2", 32'(done_rdata[bd+2]), 32'h76);
        end

        // 3: 13-write init burst with reader waiting
        do_reset(); eng_delay = 3;
        b = start_cyc.size(); eb = eng_log.size();
        for (int i = 0; i < 13; i++) push(0, 1'b1, init_addr[i], 8'(3 * i + 1));
        push(2, 1'b0, 8'h30, 8'h00);
        drain(2000, "t3_drain");
        chk("t3_nstart", 32'(start_cyc.size() - b), 32'd14);
        if (start_cyc.size() >= b + 14 && eng_log.size() >= eb + 14) begin
            for (int i = 0; i < 13; i++) begin
                chk("t3_owner", 32'(start_grant[b+i]), 32'h1);
                chk("t3_order", 32'(eng_log[eb+i]), 32'({1'b1, init_addr[i], 8'(3 * i + 1)}));
            end
            chk("t3_reader", 32'(start_grant[b+13]), 32'h4);
        end

        // 4: 14-write init burst with writer waiting
        do_reset(); eng_delay = 1;
        b = start_cyc.size();
        for (int i = 0; i < 14; i++) push(0, 1'b1, 8'(8'h50 + i), 8'(i));
        push(1, 1'b1, 8'h60, 8'h5A);
        drain(2000, "t4_drain");
        chk("t4_nstart", 32'(start_cyc.size() - b), 32'd15);
        if (start_cyc.size() >= b + 15) begin
            for (int i = 0; i < 13; i++) chk("t4_owner", 32'(start_grant[b+i]), 32'h1);
            chk("t4_writer", 32'(start_grant[b+13]), 32'h2);
            chk("t4_resume", 32'(start_grant[b+14]), 32'h1);
        end

        // 5: hung engine, timeout, then normal service
        do_reset(); eng_delay = 0;
        b = start_cyc.size(); bd = done_cyc.size();
        push(1, 1'b1, 8'h70, 8'hAA);
        n = 0;
        while (start_cyc.size() == b && n < 10) begin tick(); n++; end
        chk("t5_started", 32'(start_cyc.size() - b), 32'd1);
        eng_delay = 2;
        push(2, 1'b0, 8'h71, 8'h00);
        drain(600, "t5_drain");
        chk("t5_ndone", 32'(done_cyc.size() - bd), 32'd2);
        if (start_cyc.size() >= b + 2 && done_cyc.size() >= bd + 2) begin
            chk("t5_to_lat", 32'(done_cyc[bd] - start_cyc[b]), 32'd201);
            chk("t5_to_done", 32'(done_val[bd]), 32'h2);
            chk("t5_to_err", 32'(done_err[bd]), 32'h2);
            chk("t5_to_rdata", 32'(done_rdata[bd]), 32'h00);
            chk("t5_next_owner", 32'(start_grant[b+1]), 32'h4);
            chk("t5_next_err", 32'(done_err[bd+1]), 32'h0);
            chk("t5_next_rdata", 32'(done_rdata[bd+1]), 32'h15);
        end

        // 6: reset during WAIT aborts silently, request re-served
        do_reset(); eng_delay = 0;
        b = start_cyc.size(); bd = done_cyc.size();
        push(2, 1'b0, 8'h33, 8'h00);
        n = 0;
        while (start_cyc.size() == b && n < 10) begin tick(); n++; end
        tick(); tick();
        reset = 1'b1; tick();
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_err", 32'(err), 32'h0);
        chk("t6_start", 32'(bus_start), 32'h0);
        chk("t6_addr", 32'(bus_addr), 32'h0);
        eng_delay = 4; reset = 1'b0;
        drain(100, "t6_drain");
        chk("t6_nstart", 32'(start_cyc.size() - b), 32'd2);
        chk("t6_ndone", 32'(done_cyc.size() - bd), 32'd1);
        if (done_cyc.size() > bd) begin
            chk("t6_redone", 32'(done_val[bd]), 32'h4);
            chk("t6_rdata", 32'(done_rdata[bd]), 32'h57);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
